// File: rtl/disp_pkg.sv
// Shared constants and types for the display pixel buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package disp_pkg;

  localparam int BURST_LEN = 16;  // beats per VRAM read burst
  localparam int AXI_DW    = 64;  // AXI read-data width
  localparam int PIX_DW    = 32;  // one XRGB pixel

  // XRGB field offsets inside a 32-bit pixel; bits [31:24] are padding.
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/disp_pixbuf_fifo.sv
// Generic single-clock FIFO over a flop array with push/pop/flush and word count.
// Latency: head word visible on rd_dat the cycle after the push that made it head.
// Backpressure: push while full is dropped, pop while empty is ignored; flush wins over both.
//
// Ports: clk/rst_n; push/push_dat write side; pop read side; flush clears pointers;
//        full/empty/count reflect current state; count_next is the count after this edge;
//        rd_dat is the head word taken from the storage registers.
module disp_pixbuf_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic [DW-1:0]            rd_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Modular pointer difference is always 0..DEPTH, so no overflow handling.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign count_next = wr_ptr_d - rd_ptr_d;
  assign rd_dat     = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/disp_pixbuf.sv
// Pixel buffer between the VRAM read controller and the display output stage.
// Latency: PIX_REQ in cycle N gives PIX_VALID and RGB in cycle N+1.
// Backpressure: BUF_WREADY high only while a whole burst fits; requests on empty flag UNDERFLOW.
//
// Ports: ACLK/ARST_N; RDATA/RVALID/RREADY write beats (two XRGB pixels, low half first);
//        VRSTART flushes for a new frame; DISPON=0 blanks output without stalling;
//        PIX_REQ/PIX_VALID/PIX_R/G/B pixel stream; UNDERFLOW sticky until VRSTART.
// Optional: define DISP_PIXBUF_LEVEL_EN to add the registered word count on LEVEL.
module disp_pixbuf
  import disp_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int BURST_LEN = disp_pkg::BURST_LEN
) (
  input  logic                   ACLK,
  input  logic                   ARST_N,
  input  logic [AXI_DW-1:0]      RDATA,
  input  logic                   RVALID,
  input  logic                   RREADY,
  input  logic                   VRSTART,
  input  logic                   DISPON,
  input  logic                   PIX_REQ,
  output logic                   BUF_WREADY,
  output logic                   PIX_VALID,
  output logic [7:0]             PIX_R,
  output logic [7:0]             PIX_G,
  output logic [7:0]             PIX_B,
  output logic                   UNDERFLOW
`ifdef DISP_PIXBUF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] LEVEL
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic              take;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [AXI_DW-1:0] rd_dat;
  logic [PIX_DW-1:0] pix_word;

  logic phase_q,     phase_d;
  logic underflow_q, underflow_d;
  logic wready_q,    wready_d;
  logic pix_vld_q,   pix_vld_d;
  rgb_t pix_q,       pix_d;

  assign push = RVALID & RREADY;
  // A request on empty is answered (black) but must not move phase or pointers.
  assign take = PIX_REQ & ~empty;
  // The word leaves the FIFO only once its upper pixel has been taken.
  assign pop  = take & phase_q;

  disp_pixbuf_fifo #(
    .DW    (AXI_DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (ACLK),
    .rst_n      (ARST_N),
    .push       (push),
    .push_dat   (RDATA),
    .pop        (pop),
    .flush      (VRSTART),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .count_next (count_next),
    .rd_dat     (rd_dat)
  );

  assign pix_word = phase_q ? rd_dat[PIX_DW +: PIX_DW] : rd_dat[0 +: PIX_DW];

  always_comb begin
    phase_d     = phase_q;
    underflow_d = underflow_q | (PIX_REQ & empty);
    if (take) phase_d = ~phase_q;
    if (VRSTART) begin
      phase_d     = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Looking at count_next keeps the flag current on the cycle a burst lands;
  // a drop mid-burst is harmless because the controller samples it at burst end.
  assign wready_d  = (DEPTH - int'(count_next)) >= BURST_LEN;
  assign pix_vld_d = PIX_REQ;

  // Blanking only masks the value; consumption continues so the frame stays aligned.
  always_comb begin
    pix_d = '0;
    if (take && DISPON) begin
      pix_d.r = pix_word[R_LSB +: 8];
      pix_d.g = pix_word[G_LSB +: 8];
      pix_d.b = pix_word[B_LSB +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      phase_q     <= 1'b0;
      underflow_q <= 1'b0;
      wready_q    <= 1'b0;
      pix_vld_q   <= 1'b0;
      pix_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      underflow_q <= underflow_d;
      wready_q    <= wready_d;
      pix_vld_q   <= pix_vld_d;
      pix_q       <= pix_d;
    end
  end

  assign BUF_WREADY = wready_q;
  assign PIX_VALID  = pix_vld_q;
  assign PIX_R      = pix_q.r;
  assign PIX_G      = pix_q.g;
  assign PIX_B      = pix_q.b;
  assign UNDERFLOW  = underflow_q;

`ifdef DISP_PIXBUF_LEVEL_EN
  logic [CW-1:0] level_q, level_d;

  assign level_d = count_next;

  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) level_q <= '0;
    else         level_q <= level_d;
  end

  assign LEVEL = level_q;
`endif

  // Padding byte, full flag and live count are not needed at this level.
  logic unused_ok;
  assign unused_ok = &{1'b0, full, count, pix_word[PIX_DW-1:R_LSB+8]};

endmodule

// File: tb/tb_disp_pixbuf.sv
// Self-checking bench for disp_pixbuf: pixel-stream reference model plus scoreboard.
// Latency: expected pixels are queued at the request edge and popped when PIX_VALID shows.
// Backpressure: stimulus never pushes into a full buffer; doing so is reported.
module tb_disp_pixbuf;

  localparam int DEPTH = 64;
  localparam int BL    = 16;

  logic        ACLK = 1'b0;
  logic        ARST_N;
  logic [63:0] RDATA;
  logic        RVALID, RREADY, VRSTART, DISPON, PIX_REQ;
  logic        BUF_WREADY, PIX_VALID, UNDERFLOW;
  logic [7:0]  PIX_R, PIX_G, PIX_B;
`ifdef DISP_PIXBUF_LEVEL_EN
  logic [6:0]  LEVEL;
`endif

  always #5 ACLK = ~ACLK;

  disp_pixbuf #(.DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .ACLK       (ACLK),
    .ARST_N     (ARST_N),
    .RDATA      (RDATA),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .VRSTART    (VRSTART),
    .DISPON     (DISPON),
    .PIX_REQ    (PIX_REQ),
    .BUF_WREADY (BUF_WREADY),
    .PIX_VALID  (PIX_VALID),
    .PIX_R      (PIX_R),
    .PIX_G      (PIX_G),
    .PIX_B      (PIX_B),
    .UNDERFLOW  (UNDERFLOW)
`ifdef DISP_PIXBUF_LEVEL_EN
    ,
    .LEVEL      (LEVEL)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer as a plain stream of pending XRGB pixels.
  logic [31:0] pixq[$];
  logic [23:0] exq[$];
  bit          exp_uf = 1'b0;
  bit          exp_wr = 1'b0;
  bit          mon_en = 1'b0;

  // Words held = pixels pending rounded up (a half-consumed word still occupies a slot).
  function automatic int words();
    return (pixq.size() + 1) / 2;
  endfunction

  task automatic cyc(input bit rv, input bit rr, input logic [63:0] d,
                     input bit req, input bit vr, input bit don);
    int          w0;
    bit          was_empty;
    logic [31:0] p;
    RVALID = rv; RREADY = rr; RDATA = d; PIX_REQ = req; VRSTART = vr; DISPON = don;
    @(posedge ACLK);
    w0        = words();
    was_empty = (pixq.size() == 0);
    if (req) begin
      if (was_empty) exq.push_back(24'h0);
      else begin
        p = pixq.pop_front();
        exq.push_back(don ? p[23:0] : 24'h0);
      end
    end
    if (vr) begin
      pixq.delete();
      exp_uf = 1'b0;
    end else begin
      if (req && was_empty) exp_uf = 1'b1;
      if (rv && rr) begin
        checks++;
        if (w0 >= DEPTH) begin
          errors++;
          $display("FAIL push_while_full words=%0d required below %0d", w0, DEPTH);
        end else begin
          pixq.push_back(d[31:0]);
          pixq.push_back(d[63:32]);
        end
      end
    end
    exp_wr = (DEPTH - words()) >= BL;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 64'h0, 0, 0, 1);
  endtask

  task automatic wr(input logic [63:0] d);
    cyc(1, 1, d, 0, 0, 1);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a pixel.
  always @(negedge ACLK) begin
    if (mon_en) begin : mon
      logic [23:0] e;
      checks++;
      if (PIX_VALID) begin
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL pix_valid got 1 required 0 at %0t", $time);
        end else begin
          e = exq.pop_front();
          if ({PIX_R, PIX_G, PIX_B} !== e) begin
            errors++;
            $display("FAIL pix_rgb got %h required %h at %0t", {PIX_R, PIX_G, PIX_B}, e, $time);
          end
        end
      end else if (exq.size() != 0) begin
        errors++;
        e = exq.pop_front();
        $display("FAIL pix_valid got 0 required 1 (pixel %h) at %0t", e, $time);
      end
      checks++;
      if (UNDERFLOW !== exp_uf) begin
        errors++;
        $display("FAIL underflow got %b required %b at %0t", UNDERFLOW, exp_uf, $time);
      end
      checks++;
      if (BUF_WREADY !== exp_wr) begin
        errors++;
        $display("FAIL buf_wready got %b required %b words=%0d at %0t",
                 BUF_WREADY, exp_wr, words(), $time);
      end
`ifdef DISP_PIXBUF_LEVEL_EN
      checks++;
      if (int'(LEVEL) != words()) begin
        errors++;
        $display("FAIL level got %0d required %0d at %0t", LEVEL, words(), $time);
      end
`endif
    end
  end

  initial begin
    logic [31:0] lo;
    bit          rv, rr, rq, vr, dn;
    ARST_N = 1'b0; RDATA = '0; RVALID = 0; RREADY = 0; VRSTART = 0; DISPON = 1; PIX_REQ = 0;
    #2 mon_en = 1'b1;
    repeat (2) begin
      @(negedge ACLK);
      checks++;
      if ({PIX_R, PIX_G, PIX_B} !== 24'h0) begin
        errors++;
        $display("FAIL reset_rgb got %h required 000000", {PIX_R, PIX_G, PIX_B});
      end
    end
    @(posedge ACLK);
    #1 ARST_N = 1'b1;
    idle(2);

    // One burst with a known ramp in the blue channel, then drain it.
    for (int k = 0; k < 16; k++) begin
      lo = 32'h0000AA00 + 32'(2 * k);
      wr({lo + 32'd1, lo});
    end
    for (int i = 0; i < 32; i++) cyc(0, 0, 64'h0, 1, 0, 1);
    idle(2);

    // Fill to the BUF_WREADY threshold and one past it, then free two words.
    for (int i = 0; i < 48; i++) wr(rnd64());
    wr(rnd64());
    for (int i = 0; i < 4; i++) cyc(0, 0, 64'h0, 1, 0, 1);
    idle(1);
    cyc(0, 0, 64'h0, 0, 1, 1);
    idle(1);

    // Underflow, recovery, and stickiness until the next frame start.
    cyc(0, 0, 64'h0, 1, 0, 1);
    idle(1);
    wr(64'h00123456_00ABCDEF);
    cyc(0, 0, 64'h0, 1, 0, 1);
    cyc(0, 0, 64'h0, 1, 0, 1);
    idle(2);
    cyc(0, 0, 64'h0, 0, 1, 1);
    idle(1);

    // Flush colliding with a push and a pop, then refill.
    for (int i = 0; i < 40; i++) wr(rnd64());
    cyc(1, 1, rnd64(), 1, 1, 1);
    idle(1);
    wr(64'h11FF8040_22102030);
    cyc(0, 0, 64'h0, 1, 0, 1);
    cyc(0, 0, 64'h0, 1, 0, 1);
    idle(1);

    // Blanked requests still consume pixels.
    for (int i = 0; i < 4; i++) wr(rnd64());
    for (int i = 0; i < 4; i++) cyc(0, 0, 64'h0, 1, 0, 0);
    cyc(0, 0, 64'h0, 1, 0, 1);
    idle(1);
    cyc(0, 0, 64'h0, 0, 1, 1);
    idle(1);

    // Randomized traffic under the no-push-when-full contract.
    for (int i = 0; i < 800; i++) begin
      rv = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 3) != 0) && (words() < DEPTH);
      rq = ($urandom_range(0, 9) < 4);
      vr = ($urandom_range(0, 99) == 0);
      dn = ($urandom_range(0, 7) != 0);
      cyc(rv, rr, rnd64(), rq, vr, dn);
    end
    idle(3);

    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
